variable_table_loader: RTL and testbench
========================================

VARIABLE_TABLE_LOADER -- requirements
Module: variable_table_loader

Interface
REQ-001 SHALL have parameter VARIABLE_ADDRESS_WIDTH, default 11, the table address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, the packed stream word width.
REQ-003 SHALL have ports: clk_i  in  1  single clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: load_start_i  in  1  begin load; dump_start_i  in  1  begin readback.
REQ-005 SHALL have port num_vars_i  in  VARIABLE_ADDRESS_WIDTH+1  variable count, range 0..2**VARIABLE_ADDRESS_WIDTH.
REQ-006 SHALL have ports: in_data_i  in  WORD_WIDTH; in_valid_i  in  1; in_ready_o  out  1  (load stream).
REQ-007 SHALL have ports: out_data_o  out  WORD_WIDTH; out_valid_o  out  1; out_ready_i  in  1  (dump stream).
REQ-008 SHALL have ports: busy_o  out  1; done_o  out  1  one-cycle completion pulse.
REQ-009 SHALL have table-side ports: tbl_en_o, tbl_wr_en_o  out  1; tbl_addr_o  out  VARIABLE_ADDRESS_WIDTH; tbl_data_o  out  1; tbl_data_i  in  1  (read-first data, valid the cycle after a read).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD_WAIT, LOAD_WRITE, DUMP_READ, DUMP_OUT, DONE.
REQ-011 SHALL, in IDLE, latch num_vars_i on a start pulse, clear address and bit counters, and assert busy_o from the next cycle.
REQ-012 SHALL give load_start_i priority when both starts are asserted in the same cycle; starts while busy_o=1 SHALL be ignored.
REQ-013 SHALL go directly to DONE when the latched count is 0, with no table access.
REQ-014 SHALL assert in_ready_o only in LOAD_WAIT; an in_valid_i&in_ready_o beat captures in_data_i and enters LOAD_WRITE.
REQ-015 SHALL, in LOAD_WRITE, write one bit per cycle, LSB first: tbl_en_o=1, tbl_wr_en_o=1, tbl_addr_o=address counter, tbl_data_o=current bit.
REQ-016 SHALL leave LOAD_WRITE after WORD_WIDTH bits (to LOAD_WAIT) or after the last variable (to DONE); unused upper bits of the final word SHALL be discarded.
REQ-017 SHALL, in DUMP_READ, issue one read per cycle (tbl_en_o=1, tbl_wr_en_o=0) and pack each returned tbl_data_i one cycle later at bit position address mod WORD_WIDTH.
REQ-018 SHALL enter DUMP_OUT once a word is full or the last bit has been captured; unfilled upper bits SHALL be 0.
REQ-019 SHALL hold out_valid_o=1 and out_data_o stable in DUMP_OUT until out_ready_i=1, then return to DUMP_READ, or to DONE after the last word.
REQ-020 SHALL pulse done_o for exactly one cycle in DONE, then return to IDLE with busy_o=0.
REQ-021 SHALL drive tbl_en_o=0 in all states other than LOAD_WRITE and the read-issue cycles of DUMP_READ.
REQ-022 SHALL complete a full-table load with no stalls in exactly N + ceil(N/WORD_WIDTH) busy cycles plus one DONE cycle, where N = latched count.

Reset
REQ-023 SHALL, on rst_i asserted at any time, including mid-operation, force IDLE immediately and drive all outputs to 0.
REQ-024 SHALL leave table contents partially written after a reset during LOAD; no rollback.

Configuration
REQ-025 SHALL compile the dump path only when VARIABLE_TABLE_LOADER_DUMP_EN is defined.
REQ-026 SHALL, without VARIABLE_TABLE_LOADER_DUMP_EN, ignore dump_start_i, tie out_valid_o=0 and out_data_o=0, and omit the DUMP_READ and DUMP_OUT states.

Structure
REQ-027 SHALL place the FSM state encoding and the default WORD_WIDTH constant in the shared SAT package.
REQ-028 SHALL keep all logic in a single module with no sub-modules; the bit-pack shifter is inline.

Verification
REQ-029 SHALL cover this load: N=40, words 0xDEADBEEF, 0x000000A5 -> addresses 0..31 receive the bits of 0xDEADBEEF LSB first, addresses 32..39 receive 1,0,1,0,0,1,0,1, and done_o pulses once.
REQ-030 SHALL cover this dump, with DUMP_EN defined, after the load in REQ-029: N=40 -> out words 0xDEADBEEF, then 0x000000A5.
REQ-031 SHALL cover backpressure: out_ready_i held low for 10 cycles -> out_data_o stable and no further reads issued.
REQ-032 SHALL cover N=0 -> no tbl_en_o, done_o one cycle after the start, and busy_o low afterwards.
REQ-033 SHALL cover rst_i asserted on the fifth write cycle -> state IDLE, all outputs 0, and a new load_start_i accepted normally.
REQ-034 SHALL cover simultaneous load_start_i and dump_start_i -> a load is performed, and dump_start_i while busy_o=1 is ignored.

Source files
------------

// File: rtl/variable_table_loader_pkg.sv
// Shared definitions for the variable table loader: FSM state encoding and default stream word width.
// Define VARIABLE_TABLE_LOADER_DUMP_EN to include the dump (readback) states.
package variable_table_loader_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_WRITE,
`ifdef VARIABLE_TABLE_LOADER_DUMP_EN
    DUMP_READ,
    DUMP_OUT,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/variable_table_loader.sv
// Moves a 1-bit-wide variable table to and from a packed word stream, LSB first.
// Define VARIABLE_TABLE_LOADER_DUMP_EN to build the readback (dump) path.
module variable_table_loader
  import variable_table_loader_pkg::*;
#(
  parameter int VARIABLE_ADDRESS_WIDTH = 11,
  parameter int WORD_WIDTH             = DEFAULT_WORD_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              load_start_i,
  input  logic                              dump_start_i,
  input  logic [VARIABLE_ADDRESS_WIDTH:0]   num_vars_i,
  input  logic [WORD_WIDTH-1:0]             in_data_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  output logic [WORD_WIDTH-1:0]             out_data_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              tbl_en_o,
  output logic                              tbl_wr_en_o,
  output logic [VARIABLE_ADDRESS_WIDTH-1:0] tbl_addr_o,
  output logic                              tbl_data_o,
  input  logic                              tbl_data_i
);

  localparam int AW = VARIABLE_ADDRESS_WIDTH;
  localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  state_t                r_state;
  state_t                w_next;
  logic [AW:0]           r_numVars;
  logic [AW:0]           r_addr;
  logic [BW-1:0]         r_bitCnt;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  w_lastVar;
  logic                  w_wordEnd;
  logic                  w_startDump;

  assign w_lastVar = (r_addr + 1'b1) == r_numVars;
  assign w_wordEnd = r_bitCnt == BW'(WORD_WIDTH - 1);

`ifdef VARIABLE_TABLE_LOADER_DUMP_EN
  logic                  r_stopIssue;
  logic                  r_capValid;
  logic [BW-1:0]         r_capPos;
  logic [WORD_WIDTH-1:0] r_word;
  logic                  w_issue;

  // A load request wins over a dump request raised in the same cycle
  assign w_startDump = dump_start_i & ~load_start_i;
  assign w_issue     = (r_state == DUMP_READ) && !r_stopIssue;
  assign out_valid_o = (r_state == DUMP_OUT);
  assign out_data_o  = out_valid_o ? r_word : '0;
`else
  logic w_unused;

  assign w_startDump = 1'b0;
  assign w_unused    = &{1'b0, dump_start_i, out_ready_i, tbl_data_i};
  assign out_valid_o = 1'b0;
  assign out_data_o  = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    in_ready_o  = 1'b0;
    busy_o      = (r_state != IDLE);
    done_o      = 1'b0;
    tbl_en_o    = 1'b0;
    tbl_wr_en_o = 1'b0;
    tbl_addr_o  = '0;
    tbl_data_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_start_i)
          w_next = (num_vars_i == '0) ? DONE : LOAD_WAIT;
`ifdef VARIABLE_TABLE_LOADER_DUMP_EN
        else if (w_startDump)
          w_next = (num_vars_i == '0) ? DONE : DUMP_READ;
`endif
      end
      LOAD_WAIT: begin
        in_ready_o = 1'b1;
        if (in_valid_i) w_next = LOAD_WRITE;
      end
      LOAD_WRITE: begin
        tbl_en_o    = 1'b1;
        tbl_wr_en_o = 1'b1;
        tbl_addr_o  = r_addr[AW-1:0];
        tbl_data_o  = r_shift[0];
        if (w_lastVar)      w_next = DONE;
        else if (w_wordEnd) w_next = LOAD_WAIT;
      end
`ifdef VARIABLE_TABLE_LOADER_DUMP_EN
      DUMP_READ: begin
        tbl_en_o   = w_issue;
        tbl_addr_o = w_issue ? r_addr[AW-1:0] : '0;
        // Leave only once the final read of the word has come back
        if (r_capValid && r_stopIssue) w_next = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (out_ready_i) w_next = (r_addr == r_numVars) ? DONE : DUMP_READ;
      end
`endif
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_numVars   <= '0;
      r_addr      <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
`ifdef VARIABLE_TABLE_LOADER_DUMP_EN
      r_stopIssue <= 1'b0;
      r_capValid  <= 1'b0;
      r_capPos    <= '0;
      r_word      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (load_start_i || w_startDump) begin
            r_numVars   <= num_vars_i;
            r_addr      <= '0;
            r_bitCnt    <= '0;
`ifdef VARIABLE_TABLE_LOADER_DUMP_EN
            r_stopIssue <= 1'b0;
            r_capValid  <= 1'b0;
            r_word      <= '0;
`endif
          end
        end
        LOAD_WAIT: begin
          if (in_valid_i) begin
            r_shift  <= in_data_i;
            r_bitCnt <= '0;
          end
        end
        LOAD_WRITE: begin
          r_shift  <= r_shift >> 1;
          r_addr   <= r_addr + 1'b1;
          r_bitCnt <= r_bitCnt + 1'b1;
        end
`ifdef VARIABLE_TABLE_LOADER_DUMP_EN
        DUMP_READ: begin
          // Table data lags its read by one cycle, so pack at the remembered position
          if (r_capValid) r_word[r_capPos] <= tbl_data_i;
          r_capValid <= w_issue;
          if (w_issue) begin
            r_capPos <= r_bitCnt;
            r_addr   <= r_addr + 1'b1;
            r_bitCnt <= r_bitCnt + 1'b1;
            if (w_wordEnd || w_lastVar) r_stopIssue <= 1'b1;
          end
        end
        DUMP_OUT: begin
          if (out_ready_i) begin
            r_word      <= '0;
            r_bitCnt    <= '0;
            r_stopIssue <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_variable_table_loader.sv
// Directed bench for variable_table_loader: table-driven loads plus reset, start-priority and dump sequences.
// Dump checks are built only when VARIABLE_TABLE_LOADER_DUMP_EN is defined.
module tb_variable_table_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        loadStart = 1'b0;
  logic        dumpStart = 1'b0;
  logic [11:0] numVars = '0;
  logic [31:0] inData = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        busy;
  logic        done;
  logic        tblEn;
  logic        tblWrEn;
  logic [10:0] tblAddr;
  logic        tblDataOut;
  logic        tblDataIn = 1'b0;
  logic        memClear = 1'b0;
  logic [2047:0] mem = '0;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          withDump;
    int          expBusy;
    int          expWrites;
    logic [63:0] expMem;
  } vec_t;

  vec_t vecs [7];

  variable_table_loader dut (
    .clk_i        (clock),
    .rst_i        (reset),
    .load_start_i (loadStart),
    .dump_start_i (dumpStart),
    .num_vars_i   (numVars),
    .in_data_i    (inData),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .out_data_o   (outData),
    .out_valid_o  (outValid),
    .out_ready_i  (outReady),
    .busy_o       (busy),
    .done_o       (done),
    .tbl_en_o     (tblEn),
    .tbl_wr_en_o  (tblWrEn),
    .tbl_addr_o   (tblAddr),
    .tbl_data_o   (tblDataOut),
    .tbl_data_i   (tblDataIn)
  );

  always #5 clock = ~clock;

  // Read-first single-bit table with one cycle of read latency
  always @(posedge clock) begin
    if (memClear) mem <= '0;
    else if (tblEn) begin
      if (tblWrEn) mem[tblAddr] <= tblDataOut;
      tblDataIn <= mem[tblAddr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({inReady, outValid, outData, busy, done, tblEn, tblWrEn, tblAddr, tblDataOut});
  endfunction

  // Runs one load, feeding words whenever the loader is ready, and stops in the done cycle
  task automatic applyStimulus(input int n, input logic [31:0] w0, input logic [31:0] w1,
                               input bit withDump, output int busyCycles, output int writes);
    int  wordIdx;
    int  guard;
    bit  hs;
    memClear = 1'b1;
    tick();
    memClear = 1'b0;
    numVars = 12'(n);
    loadStart = 1'b1;
    dumpStart = withDump;
    tick();
    loadStart = 1'b0;
    busyCycles = 0;
    writes = 0;
    wordIdx = 0;
    guard = 0;
    while (!done && guard < 500) begin
      if (busy) busyCycles++;
      if (tblEn && tblWrEn) writes++;
      inValid = inReady;
      inData = (wordIdx == 0) ? w0 : w1;
      hs = inValid && inReady;
      tick();
      guard++;
      if (hs) wordIdx++;
    end
    inValid = 1'b0;
    dumpStart = 1'b0;
  endtask

  initial begin
    int busyCycles;
    int writes;

    vecs[0] = '{40, 32'hDEADBEEF, 32'h000000A5, 1'b0, 42, 40, 64'h000000A5_DEADBEEF};
    vecs[1] = '{0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0,  0,  64'h0};
    vecs[2] = '{1,  32'h00000003, 32'h00000000, 1'b0, 2,  1,  64'h1};
    vecs[3] = '{32, 32'h80000001, 32'h0000FFFF, 1'b0, 33, 32, 64'h00000000_80000001};
    vecs[4] = '{33, 32'h12345678, 32'hFFFFFFFE, 1'b0, 35, 33, 64'h00000000_12345678};
    vecs[5] = '{35, 32'h00000000, 32'hFFFFFFFD, 1'b0, 37, 35, 64'h00000005_00000000};
    vecs[6] = '{2,  32'h00000002, 32'h00000000, 1'b1, 3,  2,  64'h2};

    #1;
    checkOutput("resetOutputs", allOutputs(), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].n, vecs[i].w0, vecs[i].w1, vecs[i].withDump, busyCycles, writes);
      checkOutput($sformatf("v%0d_done", i), 64'(done), 64'h1);
      checkOutput($sformatf("v%0d_busyCycles", i), 64'(busyCycles), 64'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d_writes", i), 64'(writes), 64'(vecs[i].expWrites));
      tick();
      checkOutput($sformatf("v%0d_table", i), mem[63:0], vecs[i].expMem);
      checkOutput($sformatf("v%0d_idleAfter", i), 64'({busy, done}), 64'h0);
    end

    // Reset during the fifth write cycle leaves four bits written and the loader idle
    memClear = 1'b1;
    tick();
    memClear = 1'b0;
    numVars = 12'd40;
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    inValid = 1'b1;
    inData = 32'hFFFFFFFF;
    tick();
    inValid = 1'b0;
    repeat (4) tick();
    checkOutput("fifthWriteAddr", 64'(tblAddr), 64'd4);
    reset = 1'b1;
    #1;
    checkOutput("midResetOutputs", allOutputs(), 64'h0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("partialTable", 64'(mem[7:0]), 64'h0F);
    applyStimulus(3, 32'h00000005, 32'h0, 1'b0, busyCycles, writes);
    checkOutput("reloadDone", 64'(done), 64'h1);
    checkOutput("reloadBusyCycles", 64'(busyCycles), 64'd4);
    tick();
    checkOutput("reloadTable", mem[63:0], 64'h5);

`ifdef VARIABLE_TABLE_LOADER_DUMP_EN
    begin
      int          words;
      int          reads;
      int          guard;
      bit          stalled;
      logic [31:0] got [2];
      got[0] = '0;
      got[1] = '0;
      applyStimulus(40, 32'hDEADBEEF, 32'h000000A5, 1'b0, busyCycles, writes);
      tick();
      numVars = 12'd40;
      dumpStart = 1'b1;
      tick();
      dumpStart = 1'b0;
      checkOutput("dumpFirstRead", 64'({busy, tblEn, tblWrEn, tblAddr}), {50'h0, 1'b1, 1'b1, 1'b0, 11'd0});
      words = 0;
      reads = 0;
      guard = 0;
      stalled = 1'b0;
      while (!done && guard < 1000) begin
        if (tblEn && !tblWrEn) reads++;
        if (outValid && !stalled) begin
          outReady = 1'b0;
          for (int k = 0; k < 10; k++) begin
            tick();
            guard++;
            checkOutput($sformatf("stall%0d", k), 64'({outValid, tblEn, outData}), {30'h0, 1'b1, 1'b0, 32'hDEADBEEF});
          end
          stalled = 1'b1;
        end
        outReady = outValid;
        if (outValid && words < 2) got[words] = outData;
        if (outValid) words++;
        tick();
        guard++;
      end
      outReady = 1'b0;
      checkOutput("dumpDone", 64'(done), 64'h1);
      checkOutput("dumpWords", 64'(words), 64'd2);
      checkOutput("dumpReads", 64'(reads), 64'd40);
      checkOutput("dumpWord0", 64'(got[0]), 64'hDEADBEEF);
      checkOutput("dumpWord1", 64'(got[1]), 64'h000000A5);
      tick();
      checkOutput("dumpIdleAfter", 64'({busy, done, outValid}), 64'h0);
    end
`else
    dumpStart = 1'b1;
    numVars = 12'd8;
    tick();
    dumpStart = 1'b0;
    checkOutput("dumpIgnored", 64'({busy, outValid, tblEn}), 64'h0);
    tick();
    checkOutput("dumpStillIdle", 64'({busy, done, outValid}), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
